dsp_echo_writer: RTL

Echo-buffer write engine for the S-DSP. Once per 64-cycle sample period it takes the stereo echo sample (post-FIR, post-feedback) from the mixer and writes it as four bytes into ARAM at the current echo offset. It is the write-side counterpart of the echo-buffer read slots in the DSP schedule. It shares the `major_step` timebase with the DSP core and owns the ARAM bus only during its write slot.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/dsp_echo_offset_counter.sv | 56 +++++
 rtl/dsp_echo_writer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared S-DSP definitions: register addresses, echo buffer constants and
// the echo writer state encoding.
package dsp_pkg;

    localparam logic [7:0] REG_FLG = 8'h6C;
    localparam logic [7:0] REG_ESA = 8'h6D;
    localparam logic [7:0] REG_EDL = 8'h7D;

    localparam int FLG_ECEN_BIT     = 5;
    localparam int ECHO_FRAME_BYTES = 4;    // L lo, L hi, R lo, R hi
    localparam int ECHO_EDL_GRANULE = 2048; // bytes of buffer per EDL step

    typedef enum logic [2:0] {
        WS_IDLE,
        WS_W0,
        WS_W1,
        WS_W2,
        WS_W3
    } echo_writer_state_t;

endpackage

// File: rtl/dsp_echo_offset_counter.sv
// Echo buffer offset counter, shared by the echo writer and reader.
// Advances by one frame per advance pulse, wraps to 0 at the buffer limit and
// latches ESA/EDL only at wrap (and at reset) so mid-buffer register writes
// take effect on the next pass.
//   clock, reset : clock, synchronous active-high reset
//   esa, edl     : live ESA page / EDL registers
//   advance      : frame completed, step the offset
//   offset       : current byte offset into the buffer
//   base_page    : latched ESA page used for addressing
//   wrapped      : one-cycle pulse when the offset returns to 0
module dsp_echo_offset_counter
    import dsp_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  esa,
    input  logic [3:0]  edl,
    input  logic        advance,
    output logic [14:0] offset,
    output logic [7:0]  base_page,
    output logic        wrapped
);

    logic [3:0]  limit_edl;
    logic [15:0] limit;
    logic [15:0] next_off;

    // EDL=0 still gives a one-frame buffer rather than zero length.
    always_comb begin
        limit    = (limit_edl == 4'd0) ? 16'(ECHO_FRAME_BYTES)
                                       : 16'(limit_edl) * 16'(ECHO_EDL_GRANULE);
        next_off = {1'b0, offset} + 16'(ECHO_FRAME_BYTES);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            offset    <= '0;
            wrapped   <= 1'b0;
            base_page <= esa;
            limit_edl <= edl;
        end else begin
            wrapped <= 1'b0;
            if (advance) begin
                if (next_off >= limit) begin
                    offset    <= '0;
                    wrapped   <= 1'b1;
                    base_page <= esa;
                    limit_edl <= edl;
                end else begin
                    offset <= offset + 15'(ECHO_FRAME_BYTES);
                end
            end
        end
    end

endmodule

// File: rtl/dsp_echo_writer.sv
// Echo buffer write engine. Once per 64-step period it writes the held
// stereo echo sample as four bytes into ARAM at the current echo offset.
//   clock, reset        : clock, synchronous active-high reset
//   major_step          : DSP schedule step 0..63
//   esa, edl            : echo start page / echo delay registers
//   echo_write_disable  : FLG ECEN, sampled at burst start
//   sample_l/r, sample_valid, sample_ready : sample handshake
//   ram_address, ram_data_out, ram_write_enable : ARAM write port
//   echo_offset         : current buffer offset (shared with echo reader)
//   wrapped             : pulse in the cycle after a wrapping burst
//   underrun            : pulse in W0 when no fresh sample was available
module dsp_echo_writer
    import dsp_pkg::*;
#(
    parameter int WRITE_SLOT = 48
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  major_step,
    input  logic [7:0]  esa,
    input  logic [3:0]  edl,
    input  logic        echo_write_disable,
    input  logic [15:0] sample_l,
    input  logic [15:0] sample_r,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [15:0] ram_address,
    output logic [7:0]  ram_data_out,
    output logic        ram_write_enable,
    output logic [14:0] echo_offset,
    output logic        wrapped,
    output logic        underrun
);

    localparam logic [5:0] START_STEP = 6'(WRITE_SLOT);

    echo_writer_state_t state;
    logic [15:0] hold_l, hold_r;
    logic        fresh;
    logic        accept;
    logic [7:0]  base_page;

    assign accept = sample_valid && sample_ready;

    dsp_echo_offset_counter u_offset (
        .clock     (clock),
        .reset     (reset),
        .esa       (esa),
        .edl       (edl),
        .advance   (state == WS_W3),
        .offset    (echo_offset),
        .base_page (base_page),
        .wrapped   (wrapped)
    );

    function automatic logic [7:0] frame_byte(input logic [15:0] l, input logic [15:0] r,
                                              input logic [1:0] k);
        case (k)
            2'd0:    return l[7:0];
            2'd1:    return l[15:8];
            2'd2:    return r[7:0];
            default: return r[15:8];
        endcase
    endfunction

    // 16-bit sum wraps naturally past 0xFFFF.
    function automatic logic [15:0] byte_addr(input logic [7:0] page, input logic [14:0] off,
                                              input logic [1:0] k);
        return {page, 8'h00} + {1'b0, off} + 16'(k);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= WS_IDLE;
            hold_l           <= '0;
            hold_r           <= '0;
            fresh            <= 1'b0;
            sample_ready     <= 1'b1;
            ram_address      <= '0;
            ram_data_out     <= '0;
            ram_write_enable <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                hold_l <= sample_l;
                hold_r <= sample_r;
                fresh  <= 1'b1;
            end
            case (state)
                WS_IDLE: begin
                    if (major_step == START_STEP) begin
                        state            <= WS_W0;
                        sample_ready     <= 1'b0;
                        ram_write_enable <= !echo_write_disable;
                        ram_address      <= byte_addr(base_page, echo_offset, 2'd0);
                        // A sample arriving on this very edge is the one written.
                        ram_data_out     <= accept ? sample_l[7:0] : hold_l[7:0];
                        underrun         <= !(fresh || accept);
                    end
                end
                WS_W0: begin
                    state        <= WS_W1;
                    ram_address  <= byte_addr(base_page, echo_offset, 2'd1);
                    ram_data_out <= frame_byte(hold_l, hold_r, 2'd1);
                end
                WS_W1: begin
                    state        <= WS_W2;
                    ram_address  <= byte_addr(base_page, echo_offset, 2'd2);
                    ram_data_out <= frame_byte(hold_l, hold_r, 2'd2);
                end
                WS_W2: begin
                    state        <= WS_W3;
                    ram_address  <= byte_addr(base_page, echo_offset, 2'd3);
                    ram_data_out <= frame_byte(hold_l, hold_r, 2'd3);
                end
                WS_W3: begin
                    state            <= WS_IDLE;
                    sample_ready     <= 1'b1;
                    ram_write_enable <= 1'b0;
                    fresh            <= 1'b0;
                end
                default: state <= WS_IDLE;
            endcase
        end
    end

endmodule
